cic_capture_sequencer: RTL
==========================

Name: cic_capture_sequencer

Overview:
- Sequences one sonar receive record across NUM_CH parallel 8-bit CIC decimator channels.
- Holds the CICs in reset while idle. After a start command, it discards a programmable blanking interval of decimated samples, then captures record_len samples per channel.
- Round-robin arbitration merges the channels onto one 8-bit valid/ready stream toward the record buffer.
- Sits between the CIC bank and the capture FIFO, under control of the ping/transmit logic.

Parameters:
- NUM_CH, 4, number of CIC channels (2..8).
- CH_W, 2, channel index width; must satisfy 2**CH_W >= NUM_CH.
- LEN_W, 16, width of the blank_len, record_len and sample counters.

Ports:
- clk  input  1  system clock, shared with the CIC bank.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a record; ignored unless in IDLE.
- abort  input  1  return to IDLE and flush all holding registers; has priority over every other event.
- blank_len  input  LEN_W  number of decimated ticks to discard; sampled on an accepted start.
- record_len  input  LEN_W  number of samples per channel; sampled on an accepted start.
- cic_reset_n  output  1  drives reset_n of every CIC.
- ch_valid  input  NUM_CH  out_valid pulses from the CICs.
- ch_data  input  8*NUM_CH  CIC outputs; channel i occupies bits [8i+7:8i].
- out_valid  output  1  merged stream valid.
- out_ready  input  1  downstream ready.
- out_data  output  8  sample data.
- out_ch  output  CH_W  source channel of the current beat.
- out_last  output  1  marks the final beat of the record.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at record completion.
- overrun  output  NUM_CH  sticky per-channel drop flags.

Behaviour:
- Reset values: IDLE state, cic_reset_n=0, out_valid=0, out_last=0, busy=0, done=0, overrun=0, rr pointer=0, all holding registers empty.
- States: IDLE, BLANK, CAPTURE, DRAIN.
- IDLE:
  - cic_reset_n=0.
  - On start: latch blank_len and record_len, clear overrun and the counters.
  - Next state is BLANK if blank_len!=0; else CAPTURE if record_len!=0; else DRAIN.
- cic_reset_n=1 in BLANK, CAPTURE and DRAIN. It goes high on the cycle after start is accepted.
- Tick definition: ch_valid[0]. All CICs share one decimation phase.
- BLANK:
  - Count ticks; channel data is not stored.
  - On the tick that brings the count to blank_len: go to CAPTURE, or to DRAIN if record_len==0.
- CAPTURE:
  - A ch_valid[i] pulse loads ch_data[i], plus a last flag, into holding register i on the next edge.
  - The last flag is 1 only for channel NUM_CH-1 when the sample index == record_len-1.
  - The sample index increments on each tick.
  - On the tick with index record_len-1, that tick's samples are stored and the state goes to DRAIN.
- DRAIN:
  - No new loads.
  - When all holding registers are empty, pulse done for one cycle and return to IDLE in the same cycle.
- Holding registers: one entry per channel.
  - If ch_valid[i] arrives while register i is full and is not being transferred in that cycle, the new sample is dropped and overrun[i] is set.
  - If register i is transferring in the same cycle, the new sample loads; this is not an overrun.
- Arbitration:
  - out_valid is high when any register is full.
  - Grant goes to the first full register at or after the rr pointer, wrapping modulo NUM_CH.
  - On a transfer (out_valid and out_ready), the register empties and the rr pointer becomes grant+1, wrapping.
  - While out_valid is high and out_ready is low, the grant, out_data, out_ch and out_last are held stable. A newly filled register cannot steal the grant.
- out_data, out_ch and out_last are combinational from the granted register.
- Latency: ch_valid at edge t gives out_valid at cycle t+1 when the grant is free.
- Abort, from any state:
  - Next state is IDLE, all registers are emptied, out_valid=0 the next cycle, no done pulse.
  - overrun is retained until the next start.
- start while busy: ignored.
- reset_n low mid-record: all reset values apply on the next edge.
- If the channel NUM_CH-1 last sample is dropped by overrun, no beat carries out_last; done still pulses.

Test Plan:
- blank_len=3, record_len=2, NUM_CH=4, ticks every 16 clk with out_ready=1 -> three ticks discarded, then 8 beats ordered ch0..ch3 twice, out_last only on the 8th beat (ch3), done 1 cycle later, busy falls.
- start with blank_len=0, record_len=0 -> one cycle of DRAIN, done pulse, no out_valid, cic_reset_n high for one cycle.
- out_ready=0 for 40 clk across two ticks -> first beat held stable on ch0, overrun=4'b1111 after the second tick, 4 beats delivered after ready returns.
- Tick with out_ready toggling 1/0 -> each channel delivered exactly once, round-robin order preserved, grant never changes while stalled.
- abort asserted during CAPTURE with 2 registers full -> out_valid=0 next cycle, IDLE, no done, cic_reset_n=0. A following start clears overrun.
- start pulsed during BLANK -> no effect, latched lengths unchanged.

Source files
------------

// File: rtl/cic_capture_sequencer.sv
// Sequences one sonar receive record across NUM_CH CIC decimators: blank, capture, drain.
// Latency: a ch_valid pulse is presented on out_valid the following cycle when the grant is free.
// Backpressure: one holding register per channel; a stalled grant is frozen and excess samples set overrun.
module cic_capture_sequencer #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int LEN_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [LEN_W-1:0]    blank_len,
  input  logic [LEN_W-1:0]    record_len,
  output logic                cic_reset_n,
  input  logic [NUM_CH-1:0]   ch_valid,
  input  logic [8*NUM_CH-1:0] ch_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_data,
  output logic [CH_W-1:0]     out_ch,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic [NUM_CH-1:0]   overrun
);

  typedef enum logic [1:0] {IDLE, BLANK, CAPTURE, DRAIN} state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [CH_W-1:0]  CH_ONE  = CH_W'(1);
  localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]    CH_NUM  = (CH_W + 1)'(NUM_CH);

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  blank_q;
  logic [LEN_W-1:0]  record_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  cnt_nxt;

  logic [NUM_CH-1:0] hold_full;
  logic [NUM_CH-1:0] hold_last;
  logic [7:0]        hold_data [NUM_CH];

  logic [CH_W-1:0]   rr_ptr;
  logic              grant_lock;
  logic [CH_W-1:0]   grant_q;
  logic [CH_W-1:0]   grant_rr;
  logic [CH_W-1:0]   grant_sel;

  logic              tick;
  logic              start_ok;
  logic              capture_en;
  logic              last_idx;
  logic              xfer;
  logic [NUM_CH-1:0] xfer_vec;
  logic [NUM_CH-1:0] load_vec;
  logic [NUM_CH-1:0] drop_vec;

  // All CICs decimate in phase, so channel 0 alone defines the tick.
  assign tick        = ch_valid[0];
  assign start_ok    = (state == IDLE) && start && !abort;
  assign last_idx    = (cnt_q == record_q - LEN_ONE);
  assign busy        = (state != IDLE);
  assign cic_reset_n = (state != IDLE);

  // Round-robin search: first full register at or after rr_ptr, wrapping.
  always_comb begin : grant_search
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] idx;
    logic            found;
    grant_rr = rr_ptr;
    found    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, rr_ptr} + (CH_W + 1)'(k);
      if (sum >= CH_NUM) begin
        sum = sum - CH_NUM;
      end
      idx = sum[CH_W-1:0];
      if (!found && hold_full[idx]) begin
        grant_rr = idx;
        found    = 1'b1;
      end
    end
  end

  // A stalled beat keeps its grant so a newly filled register cannot steal it.
  assign grant_sel = grant_lock ? grant_q : grant_rr;
  assign out_valid = |hold_full;
  assign out_ch    = grant_sel;
  assign out_data  = hold_data[grant_sel];
  assign out_last  = out_valid && hold_last[grant_sel];
  assign xfer      = out_valid && out_ready;

  // Per-channel transfer, load and drop decisions for the holding registers.
  always_comb begin
    xfer_vec = '0;
    load_vec = '0;
    drop_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      xfer_vec[i] = xfer && (grant_sel == CH_W'(i));
      load_vec[i] = capture_en && ch_valid[i] && (!hold_full[i] || xfer_vec[i]);
      drop_vec[i] = capture_en && ch_valid[i] && hold_full[i] && !xfer_vec[i];
    end
  end

  // Next-state and done logic; abort overrides every other event.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt_q;
    capture_en = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_nxt = '0;
          if (blank_len != '0) begin
            state_nxt = BLANK;
          end else if (record_len != '0) begin
            state_nxt = CAPTURE;
          end else begin
            state_nxt = DRAIN;
          end
        end
      end
      BLANK: begin
        if (tick) begin
          if (cnt_q + LEN_ONE == blank_q) begin
            cnt_nxt   = '0;
            state_nxt = (record_q != '0) ? CAPTURE : DRAIN;
          end else begin
            cnt_nxt = cnt_q + LEN_ONE;
          end
        end
      end
      CAPTURE: begin
        capture_en = 1'b1;
        if (tick) begin
          if (last_idx) begin
            state_nxt = DRAIN;
          end else begin
            cnt_nxt = cnt_q + LEN_ONE;
          end
        end
      end
      DRAIN: begin
        if (hold_full == '0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt  = IDLE;
      capture_en = 1'b0;
      done       = 1'b0;
    end
  end

  // State register, lengths latched on an accepted start, tick/sample counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      blank_q  <= '0;
      record_q <= '0;
      cnt_q    <= '0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
      if (start_ok) begin
        blank_q  <= blank_len;
        record_q <= record_len;
      end
    end
  end

  // Holding register occupancy and sticky overrun flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_full <= '0;
      overrun   <= '0;
    end else if (abort) begin
      hold_full <= '0;
    end else begin
      hold_full <= (hold_full & ~xfer_vec) | load_vec;
      if (start_ok) begin
        overrun <= '0;
      end else begin
        overrun <= overrun | drop_vec;
      end
    end
  end

  // Holding register payload; only the last channel can carry the record-end flag.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (load_vec[i]) begin
        hold_data[i] <= ch_data[8*i +: 8];
        hold_last[i] <= (i == NUM_CH - 1) && last_idx;
      end
    end
  end

  // Round-robin pointer advances past each granted channel; grant freezes while stalled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr     <= '0;
      grant_lock <= 1'b0;
      grant_q    <= '0;
    end else begin
      if (xfer) begin
        rr_ptr <= (grant_sel == CH_MAX) ? '0 : grant_sel + CH_ONE;
      end
      grant_lock <= out_valid && !out_ready && !abort;
      grant_q    <= grant_sel;
    end
  end

endmodule
